// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiplier and restoring divider, one bit per clock, operating on
// operand magnitudes with the sign applied in a final cycle before DONE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [4:0]       rdIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       rdOut
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic             r_qneg;   // product / quotient sign
  logic             r_rneg;   // remainder sign
  logic [WIDTH-1:0] r_a;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_hi;     // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;     // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] r_result;
  logic [4:0]       r_tag;
  logic [4:0]       r_rd;

  // Operand decode at acceptance
  logic             w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic             w_div0, w_ovf, w_special;

  assign w_a_sgn   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
  assign w_b_sgn   = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
  assign w_a_neg   = w_a_sgn && dataA[WIDTH-1];
  assign w_b_neg   = w_b_sgn && dataB[WIDTH-1];
  assign w_a_mag   = w_a_neg ? (~dataA + 1'b1) : dataA;
  assign w_b_mag   = w_b_neg ? (~dataB + 1'b1) : dataB;
  assign w_div0    = (dataB == '0);
  assign w_ovf     = funct3[2] && !funct3[0] && (dataA == MIN) && (dataB == '1);
  assign w_special = funct3[2] && (w_div0 || w_ovf);

  // Single-iteration datapath
  logic [WIDTH:0]   w_sum, w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub, w_hi_nxt, w_lo_nxt;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_a});
  // The true difference is below the divisor, so WIDTH bits are exact
  assign w_sub   = w_shift[WIDTH-1:0] - r_a;

  // Next accumulator values: restoring-divide step or add-then-shift multiply step
  always_comb begin
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_op[2]) begin
      w_hi_nxt = w_ge ? w_sub : w_shift[WIDTH-1:0];
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_nxt = w_sum[WIDTH:1];
      w_lo_nxt = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up and result select
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0]   w_quo, w_rem, w_final;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_qneg ? (~w_prod + 1'b1) : w_prod;
  assign w_quo    = r_qneg ? (~r_lo + 1'b1) : r_lo;
  assign w_rem    = r_rneg ? (~r_hi + 1'b1) : r_hi;

  // Pick the architectural result for the latched opcode
  always_comb begin
    w_final = w_rem;
    case (r_op)
      3'b000:                 w_final = w_prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_final = w_quo;
      default:                w_final = w_rem;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rn) begin
    if (!rn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_a      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_tag    <= '0;
      r_rd     <= '0;
    end else begin
      case (r_state)
        S_CALC: begin
          if (r_cnt != LAST) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_result <= w_final;
            r_rd     <= r_tag;
            r_state  <= S_DONE;
          end
        end
        default: begin  // IDLE, DONE (back-to-back) and any illegal code
          if (start) begin
            r_state <= S_CALC;
            r_op    <= funct3;
            r_tag   <= rdIn;
            if (w_special) begin
              // Preload the final quotient/remainder and skip straight to the
              // fix-up cycle; unsigned signs leave them untouched.
              r_cnt  <= LAST;
              r_qneg <= 1'b0;
              r_rneg <= 1'b0;
              r_hi   <= w_ovf ? '0  : dataA;
              r_lo   <= w_ovf ? MIN : '1;
            end else begin
              r_cnt  <= '0;
              r_hi   <= '0;
              r_qneg <= w_a_neg ^ w_b_neg;
              r_rneg <= w_a_neg;
              if (funct3[2]) begin
                r_a  <= w_b_mag;
                r_lo <= w_a_mag;
              end else begin
                r_a  <= w_a_mag;
                r_lo <= w_b_mag;
              end
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // The fix-up cycle is not an iteration, so busy drops for it
  assign busy   = (r_state == S_CALC) && (r_cnt != LAST);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign rdOut  = r_rd;

endmodule
